// File: rtl/nextpc_predict_unit_pkg.sv
// Shared decode constants and helpers for the next-PC predictor: opcode groups, resolved-type
// encodings, link-register test and RV32 immediate extraction.
package nextpc_predict_unit_pkg;

  // inst[6:2] encodings of the control-flow opcodes
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpBranch = 5'b11000;

  typedef enum logic [1:0] {
    EmOther  = 2'd0,
    EmJalr   = 2'd1,
    EmBranch = 2'd2,
    EmJal    = 2'd3
  } em_type_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{21{i[31]}}, i[30:20]};
  endfunction

endpackage

// File: rtl/nextpc_predict_unit_return_addr_stack.sv
// Circular return-address stack. A full stack overwrites its oldest entry; a combined
// pop+push replaces the top in place.
module return_addr_stack
  import nextpc_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned PtrW     = $clog2(RAS_DEPTH),
  localparam int unsigned CntW     = $clog2(RAS_DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic [CntW-1:0] count_o
);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d, top_ptr, wr_ptr;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_pop, wr_en;

  // ptr_q names the next free slot; the power-of-two depth makes it wrap for free
  assign top_ptr = ptr_q - PtrW'(1);
  assign top_o   = mem_q[top_ptr];
  assign count_o = cnt_q;
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (do_pop && push_i) begin
      wr_en  = 1'b1;
      wr_ptr = top_ptr;
    end else if (do_pop) begin
      ptr_d = top_ptr;
      cnt_d = cnt_q - CntW'(1);
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) mem_q[wr_ptr] <= push_data_i;
    end
  end

endmodule

// File: rtl/nextpc_predict_unit.sv
// Fetch-stage next-PC predictor: owns the PC, predicts from a 2-bit BHT, a RAS and static JAL
// targets, and repairs the PC when EX/MEM reports a mispredict.
module nextpc_predict_unit
  import nextpc_predict_unit_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BHT_ENTRIES = 64,
  parameter int unsigned     RAS_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            if_valid,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            em_valid,
  input  logic [1:0]      em_type,
  input  logic [XLEN-1:0] em_pc,
  input  logic            em_taken,
  input  logic [XLEN-1:0] em_target,
  input  logic            em_pred_taken,
  input  logic [XLEN-1:0] em_pred_target,
  output logic            flush_o
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, imm_b_x, imm_j_x, ras_top;
  logic [CntW-1:0] ras_count;
  logic [4:0]      opc, rd, rs1;
  logic            is_jal, is_jalr, ras_upd, ras_push, ras_pop;
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [1:0]      bht_cur, bht_wdata;
  logic            bht_we;
  logic            unused_inst;

  assign unused_inst = ^inst[1:0];

  assign opc      = inst[6:2];
  assign rd       = inst[11:7];
  assign rs1      = inst[19:15];
  assign pc_plus4 = pc_q + XLEN'(4);
  assign imm_b_x  = XLEN'($signed(imm_b(inst)));
  assign imm_j_x  = XLEN'($signed(imm_j(inst)));
  assign rd_idx   = pc_q[IdxW+1:2];
  assign pc_o     = pc_q;

  assign is_jal  = if_valid && (opc == OpJal);
  assign is_jalr = if_valid && (opc == OpJalr);

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = pc_plus4;
    if (if_valid) begin
      case (opc)
        OpJal: begin
          pred_taken_o  = 1'b1;
          pred_target_o = pc_q + imm_j_x;
        end
        OpBranch: begin
          if (bht_q[rd_idx][1]) begin
            pred_taken_o  = 1'b1;
            pred_target_o = pc_q + imm_b_x;
          end
        end
        OpJalr: begin
          // Only return-style JALRs are predictable; others fall through and get repaired later
          if (is_link(rs1) && (rs1 != rd) && (ras_count != '0)) begin
            pred_taken_o  = 1'b1;
            pred_target_o = ras_top;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flush_o = 1'b0;
    if (em_valid) begin
      case (em_type_e'(em_type))
        EmBranch:     flush_o = (em_taken != em_pred_taken) ||
                                (em_taken && (em_target != em_pred_target));
        EmJalr, EmJal: flush_o = (em_target != em_pred_target);
        default:      flush_o = 1'b0;
      endcase
    end
  end

  // Wrong-path RAS activity is never undone; a flush only suppresses this cycle's update
  assign ras_upd  = if_valid && !stall && !flush_o;
  assign ras_push = ras_upd && (is_jal || is_jalr) && is_link(rd);
  assign ras_pop  = ras_upd && is_jalr && is_link(rs1) && (rd != rs1);

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .count_o     (ras_count)
  );

  always_comb begin
    if (flush_o)    pc_d = em_taken ? em_target : (em_pc + XLEN'(4));
    else if (stall) pc_d = pc_q;
    else            pc_d = pred_target_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Training ignores stall: resolved branches must not be lost while fetch is frozen
  assign wr_idx  = em_pc[IdxW+1:2];
  assign bht_we  = em_valid && (em_type == EmBranch);
  assign bht_cur = bht_q[wr_idx];

  always_comb begin
    bht_wdata = bht_cur;
    if (em_taken && (bht_cur != 2'b11))       bht_wdata = bht_cur + 2'b01;
    else if (!em_taken && (bht_cur != 2'b00)) bht_wdata = bht_cur - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[wr_idx] <= bht_wdata;
    end
  end

endmodule

// File: tb/tb_nextpc_predict_unit.sv
// Bench for nextpc_predict_unit: directed scenarios then random traffic, all compared each
// cycle against a queue/array reference model of the prediction rules.
module tb_nextpc_predict_unit;

  localparam int unsigned BHT   = 64;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;

  localparam logic [1:0] KOth = 2'd0;
  localparam logic [1:0] KJalr = 2'd1;
  localparam logic [1:0] KBr = 2'd2;
  localparam logic [1:0] KJal = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
  } desc_t;

  logic        clk, rst_n, stall, if_valid, em_valid, em_taken, em_pred_taken;
  logic [31:0] inst, em_pc, em_target, em_pred_target;
  logic [1:0]  em_type;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o, flush_o;

  int checks = 0;
  int failures = 0;

  desc_t       cur;
  logic [31:0] m_pc;
  int          m_bht [BHT];
  logic [31:0] m_ras [$];
  logic        e_tk, e_fl;
  logic [31:0] e_tg;

  nextpc_predict_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (BHT),
    .RAS_DEPTH   (DEPTH),
    .RESET_PC    (RPC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .if_valid       (if_valid),
    .inst           (inst),
    .pc_o           (pc_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .em_valid       (em_valid),
    .em_type        (em_type),
    .em_pc          (em_pc),
    .em_taken       (em_taken),
    .em_target      (em_target),
    .em_pred_taken  (em_pred_taken),
    .em_pred_target (em_pred_target),
    .flush_o        (flush_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic desc_t mk(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [31:0] imm);
    desc_t d;
    d.kind = k;
    d.rd   = rd;
    d.rs1  = rs1;
    d.imm  = imm;
    return d;
  endfunction

  function automatic logic [31:0] encode(input desc_t d);
    logic [31:0] u, r;
    u = d.imm;
    r = $urandom;
    case (d.kind)
      KJal:    return {u[20], u[10:1], u[11], u[19:12], d.rd, 7'b1101111};
      KJalr:   return {u[11:0], d.rs1, 3'b000, d.rd, 7'b1100111};
      KBr:     return {u[12], u[10:5], r[4:0], r[9:5], 3'b000, u[4:1], u[11], 7'b1100011};
      default: return {r[31:7], 7'b0010011};
    endcase
  endfunction

  function automatic void m_reset();
    m_pc = RPC;
    foreach (m_bht[i]) m_bht[i] = 1;
    m_ras.delete();
  endfunction

  function automatic void m_predict(output logic tk, output logic [31:0] tg);
    int idx;
    tk  = 1'b0;
    tg  = m_pc + 32'd4;
    idx = int'((m_pc >> 2) % BHT);
    if (if_valid) begin
      if (cur.kind == KJal) begin
        tk = 1'b1;
        tg = m_pc + cur.imm;
      end else if (cur.kind == KBr && m_bht[idx] >= 2) begin
        tk = 1'b1;
        tg = m_pc + cur.imm;
      end else if (cur.kind == KJalr && link(cur.rs1) && cur.rs1 != cur.rd && m_ras.size() > 0) begin
        tk = 1'b1;
        tg = m_ras[$];
      end
    end
  endfunction

  function automatic logic m_flush();
    if (!em_valid) return 1'b0;
    if (em_type == KBr) return (em_taken != em_pred_taken) || (em_taken && em_target != em_pred_target);
    if (em_type == KJalr || em_type == KJal) return em_target != em_pred_target;
    return 1'b0;
  endfunction

  function automatic void m_update();
    int idx;
    if (if_valid && !stall && !e_fl) begin
      if (cur.kind == KJalr && link(cur.rs1) && cur.rs1 != cur.rd && m_ras.size() > 0)
        void'(m_ras.pop_back());
      if ((cur.kind == KJal || cur.kind == KJalr) && link(cur.rd)) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    if (em_valid && em_type == KBr) begin
      idx = int'((em_pc >> 2) % BHT);
      if (em_taken) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
      else          m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
    end
    if (e_fl)        m_pc = em_taken ? em_target : em_pc + 32'd4;
    else if (!stall) m_pc = e_tg;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic settle_and_check();
    #1;
    m_predict(e_tk, e_tg);
    e_fl = m_flush();
    chk("pc", pc_o, m_pc);
    chk("pred_taken", 32'(pred_taken_o), 32'(e_tk));
    chk("pred_target", pred_target_o, e_tg);
    chk("flush", 32'(flush_o), 32'(e_fl));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid = 1'b0; stall = 1'b0; em_valid = 1'b0; em_type = 2'd0; em_pc = '0;
    em_taken = 1'b0; em_target = '0; em_pred_taken = 1'b0; em_pred_target = '0;
    cur = mk(KOth, 5'd0, 5'd0, 32'd0);
    inst = encode(cur);
  endtask

  task automatic fetch(input desc_t d);
    cur = d;
    inst = encode(d);
    if_valid = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] addr);
    idle();
    em_valid = 1'b1; em_type = KJal; em_taken = 1'b1;
    em_target = addr; em_pred_target = addr ^ 32'h4;
    settle_and_check();
    tick();
    idle();
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom % 5)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      3: return 5'd7;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic randomize_inputs();
    logic [31:0] r;
    logic [1:0]  k;
    logic [31:0] imm;
    k = 2'($urandom);
    case (k)
      KJal:    imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      KBr:     imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      default: imm = 32'($urandom % 4096);
    endcase
    cur      = mk(k, pick_reg(), pick_reg(), imm);
    inst     = encode(cur);
    if_valid = ($urandom % 4) != 0;
    stall    = ($urandom % 4) == 0;
    em_valid = ($urandom % 2) == 0;
    em_type  = 2'($urandom);
    r        = $urandom;
    em_pc    = {r[31:2], 2'b00};
    em_taken = (em_type == KJal || em_type == KJalr) ? 1'b1 : 1'($urandom);
    r        = $urandom;
    em_target = {r[31:2], 2'b00};
    if ($urandom % 2) begin
      em_pred_taken  = em_taken;
      em_pred_target = em_target;
    end else begin
      em_pred_taken  = 1'($urandom);
      em_pred_target = $urandom;
    end
  endtask

  logic [31:0] exp_ret [4];

  initial begin
    rst_n = 1'b0;
    idle();
    m_reset();
    @(negedge clk);

    // Reset state and free-running sequential fetch
    settle_and_check();
    chk("reset_pc", pc_o, 32'h100);
    chk("reset_flush", 32'(flush_o), 32'd0);
    rst_n = 1'b1;
    tick();
    settle_and_check();
    chk("seq_pc1", pc_o, 32'h104);
    tick();
    settle_and_check();
    chk("seq_pc2", pc_o, 32'h108);
    tick();

    // BHT training while stalled on a branch at 0x200
    redirect(32'h200);
    fetch(mk(KBr, 5'd0, 5'd0, 32'h40));
    stall = 1'b1; em_valid = 1'b1; em_type = KBr; em_pc = 32'h200;
    em_taken = 1'b1; em_pred_taken = 1'b1; em_target = 32'h240; em_pred_target = 32'h240;
    settle_and_check();
    chk("bht_weak_nt", 32'(pred_taken_o), 32'd0);
    tick();
    settle_and_check();
    chk("bht_taken", 32'(pred_taken_o), 32'd1);
    chk("bht_target", pred_target_o, 32'h240);
    tick();
    em_taken = 1'b0; em_pred_taken = 1'b0;
    settle_and_check();
    tick();
    em_valid = 1'b0;
    settle_and_check();
    chk("bht_still_taken", 32'(pred_taken_o), 32'd1);
    chk("bht_stall_pc", pc_o, 32'h200);
    tick();

    // Call/return through the RAS
    redirect(32'h300);
    fetch(mk(KJal, 5'd1, 5'd0, 32'h80));
    settle_and_check();
    chk("jal_target", pred_target_o, 32'h380);
    tick();
    fetch(mk(KJalr, 5'd0, 5'd1, 32'd0));
    settle_and_check();
    chk("ret_target", pred_target_o, 32'h304);
    chk("ret_taken", 32'(pred_taken_o), 32'd1);
    tick();
    settle_and_check();
    chk("ret_pc", pc_o, 32'h304);
    chk("ras_empty_fallback", 32'(pred_taken_o), 32'd0);
    chk("ras_empty_target", pred_target_o, 32'h308);
    tick();

    // Five pushes into a four-deep RAS lose the oldest return address
    for (int k = 0; k < 5; k++) begin
      fetch(mk(KJal, 5'd1, 5'd0, 32'h10));
      settle_and_check();
      tick();
    end
    exp_ret = '{32'h34C, 32'h33C, 32'h32C, 32'h31C};
    for (int k = 0; k < 4; k++) begin
      fetch(mk(KJalr, 5'd0, 5'd1, 32'd0));
      settle_and_check();
      chk("ras_pop_order", pred_target_o, exp_ret[k]);
      tick();
    end
    fetch(mk(KJalr, 5'd0, 5'd1, 32'd0));
    settle_and_check();
    chk("ras_oldest_lost", 32'(pred_taken_o), 32'd0);
    tick();

    // Branch mispredict overrides stall
    idle();
    stall = 1'b1; em_valid = 1'b1; em_type = KBr; em_pc = 32'h400;
    em_pred_taken = 1'b1; em_taken = 1'b0; em_target = 32'h440; em_pred_target = 32'h440;
    settle_and_check();
    chk("mispredict_flush", 32'(flush_o), 32'd1);
    tick();
    idle();
    fetch(mk(KJal, 5'd1, 5'd0, 32'hFC));
    settle_and_check();
    chk("mispredict_pc", pc_o, 32'h404);
    tick();

    // Non-return JALR: falls through, then repaired; RAS untouched
    fetch(mk(KJalr, 5'd0, 5'd7, 32'd0));
    settle_and_check();
    chk("jalr_x7_taken", 32'(pred_taken_o), 32'd0);
    chk("jalr_x7_target", pred_target_o, 32'h504);
    tick();
    idle();
    em_valid = 1'b1; em_type = KJalr; em_pc = 32'h500; em_taken = 1'b1;
    em_target = 32'h900; em_pred_target = 32'h504;
    settle_and_check();
    chk("jalr_flush", 32'(flush_o), 32'd1);
    tick();
    idle();
    fetch(mk(KJalr, 5'd0, 5'd1, 32'd0));
    settle_and_check();
    chk("jalr_repair_pc", pc_o, 32'h900);
    chk("ras_unchanged", pred_target_o, 32'h408);
    tick();

    // Mid-run asynchronous reset with a populated RAS and trained BHT
    for (int k = 0; k < 3; k++) begin
      idle();
      fetch(mk(KJal, 5'd1, 5'd0, 32'h8));
      em_valid = 1'b1; em_type = KBr; em_pc = 32'h200; em_taken = 1'b1;
      em_pred_taken = 1'b1; em_target = 32'h240; em_pred_target = 32'h240;
      settle_and_check();
      tick();
    end
    idle();
    fetch(mk(KJalr, 5'd0, 5'd1, 32'd0));
    settle_and_check();
    chk("pre_reset_ras", pred_target_o, 32'h41C);
    #1;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_reset_pc", pc_o, RPC);
    chk("async_reset_ras", 32'(pred_taken_o), 32'd0);
    tick();
    rst_n = 1'b1;
    redirect(32'h200);
    fetch(mk(KBr, 5'd0, 5'd0, 32'h40));
    settle_and_check();
    chk("async_reset_bht", 32'(pred_taken_o), 32'd0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      settle_and_check();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nextpc_predict_unit.md
Name: nextpc_predict_unit

Overview:
Parametrised successor to the fetch-stage next-PC mux. It owns the PC register and predicts the next PC from a BHT of 2-bit saturating counters, a return-address stack (RAS) and static JAL targets. It also repairs the PC on mispredicts resolved in EX/MEM. Sits between the instruction memory and the IF/ID register; drives the flush request to the pipeline control.

Parameters:
XLEN, 32, PC/data width
BHT_ENTRIES, 64, number of 2-bit counters; power of 2, >=2
RAS_DEPTH, 4, return-address stack entries; power of 2, >=2
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and all speculative state this cycle
if_valid  in  1  inst holds a valid fetched word for pc_o
inst  in  32  instruction fetched at pc_o
pc_o  out  XLEN  current fetch PC (registered)
pred_taken_o  out  1  prediction for inst: taken or redirected
pred_target_o  out  XLEN  predicted next PC (comb.); piped down with inst
em_valid  in  1  EX/MEM holds a resolved control-flow instruction
em_type  in  2  0=other, 1=JALR, 2=BRANCH, 3=JAL
em_pc  in  XLEN  PC of the resolved instruction
em_taken  in  1  branch outcome (1 for JAL/JALR)
em_target  in  XLEN  resolved target address
em_pred_taken  in  1  pred_taken_o carried with the instruction
em_pred_target  in  XLEN  pred_target_o carried with the instruction
flush_o  out  1  mispredict; IF/ID and ID/EX must be squashed

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC; all BHT counters=2'b01 (weakly not-taken); RAS count=0, pointer=0. Comb. outputs follow from reset state.
- Immediates: B, J and I formats sign-extended to XLEN. Decode uses inst[6:2].
- Prediction (comb.), when if_valid=1:
  - JAL: target = pc_o + immJ; taken=1.
  - BRANCH: counter[pc_o[log2(BHT_ENTRIES)+1:2]][1]=1 gives target pc_o+immB, taken=1; else pc_o+4, taken=0.
  - JALR with rs1 in {x1,x5}, rs1!=rd, RAS count>0: target=RAS top; taken=1.
  - Any other JALR: target pc_o+4, taken=0. This is a guaranteed mispredict, repaired in EX/MEM.
  - Other opcodes, or if_valid=0: target pc_o+4, taken=0.
- RAS updates: apply only when if_valid=1, stall=0 and flush_o=0.
  - push pc_o+4 when a JAL/JALR has rd in {x1,x5}.
  - pop when a JALR has rs1 in {x1,x5} and rd not in {x1,x5}.
  - rd and rs1 both link with rd!=rs1: pop, then push (net count unchanged, top replaced).
  - rd==rs1, both link: push only.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no-op; prediction falls back to pc_o+4.
- Mispredict (comb.): flush_o = em_valid and one of:
  - BRANCH: em_taken!=em_pred_taken, or (taken and em_target!=em_pred_target).
  - JALR/JAL: em_target!=em_pred_target.
  - em_type=0: never.
- PC update on clk edge, in priority order:
  1. flush_o: pc_o <= em_taken ? em_target : em_pc+4. Overrides stall.
  2. stall: hold.
  3. Otherwise: pc_o <= pred_target_o.
- BHT update: on every em_valid with em_type=BRANCH, regardless of stall. Index em_pc bits. Saturating +1 if taken, -1 if not. Counter stays in 0..3.
- Same-cycle read and write to one BHT entry: prediction uses the old value.
- RAS is not repaired on flush; wrong-path pushes/pops persist. This is accepted, and only costs later mispredicts.
- All PC arithmetic is modulo 2^XLEN; wrap-around is legal.

Decomposition:
- Shared package: opcode constants JAL/JALR/BRANCH (inst[6:2] encodings), em_type encodings, link-register test (x1/x5), immediate-extract functions.
- One sub-module: return_addr_stack, parameterised on XLEN and RAS_DEPTH. Ports: push, pop, push_data, top, count. Pop-then-push semantics live inside it.
- BHT counters stay inline.

Test Plan:
- Reset with RESET_PC=0x100, release rst_n, if_valid=0 -> pc_o 0x100, 0x104, 0x108 on successive edges; flush_o=0.
- BRANCH at 0x200 with immB=+0x40: resolve em_taken=1 twice -> counter 01->10->11; next fetch predicts 0x240 with pred_taken_o=1; one not-taken resolve -> still predicts taken (10).
- JAL x1 at 0x300 (+0x80), then JALR x0,0(x1) at 0x380 -> pred_target_o=0x304 and RAS count returns to 0. Five pushes with RAS_DEPTH=4 -> count=4, oldest entry lost.
- Mispredict: em_type=BRANCH, em_pc=0x400, em_pred_taken=1, em_taken=0, with stall=1 -> flush_o=1 and pc_o=0x404 next edge despite stall.
- JALR rs1=x7 at 0x500 resolves to 0x900 with em_pred_target=0x504 -> flush_o=1, pc_o=0x900; no RAS change.
- Assert rst_n mid-run with RAS count=3 and BHT counters trained -> immediate pc_o=RESET_PC, all counters 01, count 0.
